// File: rtl/snake_pio_pkg.sv
// Shared constants for the snake controller input PIO: register word
// addresses and the edge-capture mode encoding.
package snake_pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_IRQMASK = 2'd1;
    localparam logic [1:0] ADDR_EDGECAP = 2'd2;
    localparam logic [1:0] ADDR_MODE    = 2'd3;

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_ANY  = 2'b10,
        MODE_OFF  = 2'b11
    } mode_e;

endpackage

// File: rtl/snake_pio_debounce.sv
// One input bit: synchroniser chain followed by a stable-count debounce
// filter. With DEBOUNCE_CYCLES=0 the filter is a single register stage.
module snake_pio_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic reset,
    input  logic in_i,
    output logic filt_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic                   filt_q;

    // Shift the asynchronous input through the synchroniser chain.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[SYNC_STAGES-2:0], in_i};
    end

    assign sync   = sync_q[SYNC_STAGES-1];
    assign filt_o = filt_q;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            // No filtering: the filtered bit is the sync output, one cycle later.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) filt_q <= 1'b0;
                else       filt_q <= sync;
            end
        end else begin : g_filter
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0] CNT_ONE = CW'(1);

            logic [CW-1:0] cnt_q, cnt_d;
            logic          filt_d;

            // Count cycles of disagreement; any agreement drops the count so a
            // short glitch never reaches the filtered output.
            always_comb begin
                cnt_d  = '0;
                filt_d = filt_q;
                if (sync != filt_q) begin
                    if (cnt_q == CNT_MAX) begin
                        filt_d = sync;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
            end

            // Filter state registers.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    cnt_q  <= '0;
                    filt_q <= 1'b0;
                end else begin
                    cnt_q  <= cnt_d;
                    filt_q <= filt_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/snake_pio_in_edge.sv
// Avalon-MM input PIO: per-bit synchronise/debounce, edge capture with
// mode select, write-1-to-clear capture register, masked level interrupt.
module snake_pio_in_edge
    import snake_pio_pkg::*;
#(
    parameter int WIDTH           = 31,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);

    logic [WIDTH-1:0] filt;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] hits;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic [WIDTH-1:0] ec_q, ec_d;
    mode_e            mode_q, mode_d;
    logic [31:0]      rdata_q, rdata_d;
    logic             wr;
    logic             unused_wd;

    // Write data bits beyond the implemented registers have no storage.
    assign unused_wd = ^writedata;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            snake_pio_debounce #(
                .SYNC_STAGES     (SYNC_STAGES),
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk    (clk),
                .reset  (reset),
                .in_i   (in_port[i]),
                .filt_o (filt[i])
            );
        end
    endgenerate

    assign wr = chipselect & ~write_n;

    // Qualify filtered-vs-previous transitions by the current mode.
    always_comb begin
        hits = '0;
        unique case (mode_q)
            MODE_RISE: hits = filt & ~prev_q;
            MODE_FALL: hits = ~filt & prev_q;
            MODE_ANY:  hits = filt ^ prev_q;
            default:   hits = '0;
        endcase
    end

    // Register file next state; a new edge beats a same-cycle clear.
    always_comb begin
        clr    = '0;
        mask_d = mask_q;
        mode_d = mode_q;
        if (wr && address == ADDR_EDGECAP) clr    = writedata[WIDTH-1:0];
        if (wr && address == ADDR_IRQMASK) mask_d = writedata[WIDTH-1:0];
        if (wr && address == ADDR_MODE)    mode_d = mode_e'(writedata[1:0]);
        ec_d = (ec_q & ~clr) | hits;
    end

    // Read mux; unimplemented bits read as zero.
    always_comb begin
        rdata_d = '0;
        case (address)
            ADDR_DATA:    rdata_d[WIDTH-1:0] = filt;
            ADDR_IRQMASK: rdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGECAP: rdata_d[WIDTH-1:0] = ec_q;
            default:      rdata_d[1:0]       = mode_q;
        endcase
    end

    // All control/status state, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q  <= '0;
            mask_q  <= '0;
            ec_q    <= '0;
            mode_q  <= MODE_RISE;
            rdata_q <= '0;
        end else begin
            prev_q  <= filt;
            mask_q  <= mask_d;
            ec_q    <= ec_d;
            mode_q  <= mode_d;
            rdata_q <= rdata_d;
        end
    end

    assign readdata = rdata_q;
    assign irq      = |(ec_q & mask_q);

endmodule

// File: tb/tb_snake_pio_in_edge.sv
// Bench for snake_pio_in_edge: a debounced 31-bit instance checked every
// cycle against a history-window reference model, plus an 8-bit unfiltered
// instance for width masking.
module tb_snake_pio_in_edge;

    localparam int W  = 31;
    localparam int S  = 2;
    localparam int D  = 4;
    localparam int L  = S + D + 1;
    localparam logic [31:0] WM = 32'h7FFF_FFFF;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [1:0]   address;
    logic         chipselect, write_n;
    logic [31:0]  writedata, readdata;
    logic [W-1:0] in_port;
    logic         irq;

    logic [1:0]   address_b;
    logic         cs_b, wn_b;
    logic [31:0]  wd_b, readdata_b;
    logic [7:0]   in_port_b;
    logic         irq_b;

    snake_pio_in_edge #(.WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D)) u_dut (
        .clk(clk), .reset(rst), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .readdata(readdata),
        .in_port(in_port), .irq(irq)
    );

    snake_pio_in_edge #(.WIDTH(8), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(0)) u_dut_b (
        .clk(clk), .reset(rst), .address(address_b), .chipselect(cs_b),
        .write_n(wn_b), .writedata(wd_b), .readdata(readdata_b),
        .in_port(in_port_b), .irq(irq_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference model: m_q holds the last L input samples; the filtered bit
    // moves to v once the sync-delayed input has shown v for D+1 edges.
    logic [31:0]  m_filt, m_prev, m_ec, m_mask, m_rd;
    logic [1:0]   m_mode;
    logic [W-1:0] m_q[$];

    function automatic void m_reset();
        m_filt = '0; m_prev = '0; m_ec = '0; m_mask = '0; m_rd = '0; m_mode = '0;
        m_q = {};
        for (int i = 0; i < L; i++) m_q.push_back('0);
    endfunction

    function automatic logic m_irq();
        return |(m_ec & m_mask);
    endfunction

    function automatic void m_step();
        logic [31:0] nf, set, clr;
        logic        wr, v, ok;
        m_q.push_back(in_port);
        void'(m_q.pop_front());
        nf = m_filt;
        for (int b = 0; b < W; b++) begin
            v  = m_q[0][b];
            ok = 1'b1;
            for (int k = 1; k <= D; k++) if (m_q[k][b] !== v) ok = 1'b0;
            if (ok && v !== m_filt[b]) nf[b] = v;
        end
        case (m_mode)
            2'd0:    set = m_filt & ~m_prev;
            2'd1:    set = ~m_filt & m_prev;
            2'd2:    set = m_filt ^ m_prev;
            default: set = '0;
        endcase
        wr  = chipselect && !write_n;
        clr = (wr && address == 2'd2) ? writedata : 32'h0;
        case (address)
            2'd0:    m_rd = m_filt;
            2'd1:    m_rd = m_mask;
            2'd2:    m_rd = m_ec;
            default: m_rd = {30'h0, m_mode};
        endcase
        m_ec = ((m_ec & ~clr) | set) & WM;
        if (wr && address == 2'd1) m_mask = writedata & WM;
        if (wr && address == 2'd3) m_mode = writedata[1:0];
        m_prev = m_filt;
        m_filt = nf;
    endfunction

    // One clock: model follows the edge, outputs checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        if (rst) m_reset();
        else     m_step();
        @(negedge clk);
        chk("rd", readdata, m_rd);
        chk("irq", {31'h0, irq}, {31'h0, m_irq()});
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b0; writedata = d;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic read(input logic [1:0] a, output logic [31:0] d);
        address = a;
        tick();
        d = readdata;
    endtask

    initial begin
        logic [31:0] r;
        address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0; in_port = '0;
        address_b = '0; cs_b = 1'b0; wn_b = 1'b1; wd_b = '0; in_port_b = 8'h05;
        m_reset();

        #12;
        chk("rst_rd", readdata, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_rd_b", readdata_b, 32'h0);
        chk("rst_irq_b", {31'h0, irq_b}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Narrow, unfiltered instance: DATA, mask and mode width.
        idle(6);
        chk("b_data", readdata_b, 32'h0000_0005);
        address_b = 2'd1; cs_b = 1'b1; wn_b = 1'b0; wd_b = 32'hFFFF_FFFF;
        tick();
        cs_b = 1'b0; wn_b = 1'b1;
        tick();
        chk("b_mask", readdata_b, 32'h0000_00FF);
        address_b = 2'd3; cs_b = 1'b1; wn_b = 1'b0;
        tick();
        cs_b = 1'b0; wn_b = 1'b1;
        tick();
        chk("b_mode", readdata_b, 32'h0000_0003);
        address_b = 2'd0;

        // Debounce latency on bit 0 with its interrupt enabled.
        wr(2'd1, 32'h1);
        address = 2'd0;
        idle(2);
        in_port[0] = 1'b1;
        for (int n = 0; n <= 7; n++) begin
            tick();
            if (n == 6) begin
                chk("lat_data_e6", {31'h0, readdata[0]}, 32'h0);
                chk("lat_irq_e6", {31'h0, irq}, 32'h0);
            end
            if (n == 7) begin
                chk("lat_data_e7", {31'h0, readdata[0]}, 32'h1);
                chk("lat_irq_e7", {31'h0, irq}, 32'h1);
            end
        end
        read(2'd2, r);
        chk("lat_ec", r & 32'h1, 32'h1);
        wr(2'd2, 32'h1);
        chk("irq_clr", {31'h0, irq}, 32'h0);

        // Three-cycle glitch on bit 1 is dropped.
        in_port[1] = 1'b1; idle(3); in_port[1] = 1'b0; idle(12);
        read(2'd2, r); chk("glitch_ec", r & 32'h2, 32'h0);
        read(2'd0, r); chk("glitch_data", r & 32'h2, 32'h0);

        // Falling-only mode on bit 2.
        wr(2'd3, 32'h1); wr(2'd2, 32'hFFFF_FFFF);
        in_port[2] = 1'b1; idle(10);
        read(2'd2, r); chk("fall_on_rise", r & 32'h4, 32'h0);
        in_port[2] = 1'b0; idle(10);
        read(2'd2, r); chk("fall_on_fall", r & 32'h4, 32'h4);

        // Any-edge mode.
        wr(2'd3, 32'h2); wr(2'd2, 32'hFFFF_FFFF);
        in_port[2] = 1'b1; idle(10);
        read(2'd2, r); chk("any_rise", r & 32'h4, 32'h4);
        wr(2'd2, 32'h4);
        in_port[2] = 1'b0; idle(10);
        read(2'd2, r); chk("any_fall", r & 32'h4, 32'h4);

        // Capture disabled.
        wr(2'd3, 32'h3); wr(2'd2, 32'hFFFF_FFFF);
        in_port[2] = 1'b1; idle(10); in_port[2] = 1'b0; idle(10);
        read(2'd2, r); chk("off_none", r & 32'h4, 32'h0);

        // Clear and capture on bit 3 in the same edge: capture wins.
        wr(2'd3, 32'h0); wr(2'd2, 32'hFFFF_FFFF);
        in_port[3] = 1'b1;
        idle(7);
        wr(2'd2, 32'h8);
        read(2'd2, r); chk("collide", r & 32'h8, 32'h8);

        // Reset during a debounce count, input held high across it.
        in_port[4] = 1'b1;
        idle(4);
        rst = 1'b1;
        #1;
        m_reset();
        chk("mid_rst_rd", readdata, 32'h0);
        chk("mid_rst_irq", {31'h0, irq}, 32'h0);
        tick();
        rst = 1'b0;
        wr(2'd1, 32'h10);
        for (int n = 1; n <= 7; n++) begin
            tick();
            if (n == 6) chk("post_rst_e6", {31'h0, irq}, 32'h0);
            if (n == 7) chk("post_rst_e7", {31'h0, irq}, 32'h1);
        end

        // Randomised traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(4, 0) == 0) in_port[$urandom_range(W - 1, 0)] ^= 1'b1;
            chipselect = ($urandom_range(3, 0) == 0);
            write_n    = $urandom_range(1, 0) == 1;
            address    = 2'($urandom_range(3, 0));
            writedata  = $urandom;
            if (i == 300) begin
                rst = 1'b1;
                #1;
                m_reset();
                chk("rand_rst_rd", readdata, 32'h0);
                tick();
                rst = 1'b0;
            end else begin
                tick();
            end
        end
        chipselect = 1'b0; write_n = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
